// File: rtl/rldramii_dmaster_byte_fifo.sv
// rldramii_dmaster_byte_fifo: FWFT byte FIFO behind the dmaster timing adapter, with overflow drop counting.
// Optional DMASTER_FIFO_LEVEL_EN adds a registered fill_level output; otherwise fill_level is tied to 0.
module rldramii_dmaster_byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              clr_ovf,
  output logic              ovf_flag,
  output logic [7:0]        drop_cnt,
  output logic [ADDR_W:0]   fill_level
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ZERO = '0;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_inc;
  logic [ADDR_W:0]   count, count_nxt;
  logic [DATA_W-1:0] head_nxt;
  logic              push, pop, full, ovf;
  // The head register is reloaded from in_data when the pushed byte becomes the head,
  // otherwise from the slot behind the popped one.
  always_comb begin
    full      = count == FULL;
    pop       = out_valid & out_ready;
    push      = in_valid & (!full | pop);
    ovf       = in_valid & full & !pop;
    rd_inc    = rd_ptr + ADDR_W'(1);
    count_nxt = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    head_nxt  = (push & (count == (pop ? ONE : ZERO))) ? in_data : pop ? mem[rd_inc] : out_data;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      ovf_flag  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      wr_ptr    <= push ? wr_ptr + ADDR_W'(1) : wr_ptr;
      rd_ptr    <= pop ? rd_inc : rd_ptr;
      count     <= count_nxt;
      out_valid <= count_nxt != ZERO;
      out_data  <= head_nxt;
      in_ready  <= count_nxt != FULL;
      ovf_flag  <= clr_ovf ? 1'b0 : (ovf | ovf_flag);
      drop_cnt  <= clr_ovf ? 8'd0 : (ovf && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (!reset && ovf) $display("%m: overflow, byte 0x%0h dropped", in_data);
`endif
`ifdef DMASTER_FIFO_LEVEL_EN
  always_ff @(posedge clk)
    fill_level <= reset ? ZERO : count_nxt;
`else
  assign fill_level = '0;
`endif
endmodule

// File: tb/tb_rldramii_dmaster_byte_fifo.sv
// tb_rldramii_dmaster_byte_fifo: table-driven directed check of the dmaster byte FIFO.
module tb_rldramii_dmaster_byte_fifo;
  typedef struct {
    int rst, iv, id, ordy, clr;
    int ov, od, chkd, ir, ovf, drop, cnt;
  } vec_t;
  logic       clk = 1'b0;
  logic       reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid, ovf_flag;
  logic [7:0] out_data, drop_cnt;
  logic [4:0] fill_level;
  int         n_vec = 0, n_mis = 0;
  vec_t       tbl[$];
  rldramii_dmaster_byte_fifo dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .clr_ovf(clr_ovf),
    .ovf_flag(ovf_flag), .drop_cnt(drop_cnt), .fill_level(fill_level)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(int rst, int iv, int id, int ordy, int clr,
                              int ov, int od, int chkd, int ir, int ovf, int drop, int cnt);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.ordy = ordy; v.clr = clr;
    v.ov = ov; v.od = od; v.chkd = chkd; v.ir = ir; v.ovf = ovf; v.drop = drop; v.cnt = cnt;
    return v;
  endfunction
  task automatic check(string n, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask
  task automatic apply(vec_t v, string n);
    @(negedge clk);
    reset = v.rst[0]; in_valid = v.iv[0]; in_data = 8'(v.id); out_ready = v.ordy[0]; clr_ovf = v.clr[0];
    @(posedge clk);
    #1;
    check({n, ".out_valid"}, int'(out_valid), v.ov);
    check({n, ".in_ready"}, int'(in_ready), v.ir);
    check({n, ".ovf_flag"}, int'(ovf_flag), v.ovf);
    check({n, ".drop_cnt"}, int'(drop_cnt), v.drop);
    if (v.chkd != 0) check({n, ".out_data"}, int'(out_data), v.od);
`ifdef DMASTER_FIFO_LEVEL_EN
    check({n, ".fill_level"}, int'(fill_level), v.cnt);
`else
    check({n, ".fill_level"}, int'(fill_level), 0);
`endif
  endtask
  initial begin
    // reset, idle, single byte FWFT
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'hA5, 1, 0, 1, 'hA5, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    // fill to full with 0x00..0x0F, head stays 0x00
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(0, 1, i, 0, 0, 1, 0, 1, i < 15 ? 1 : 0, 0, 0, i + 1));
    // three overflows, then clear
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 1, 'hE0 + k, 0, 0, 1, 0, 1, 0, 1, k + 1, 16));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 16));
    // drain: dropped bytes never appear
    for (int j = 0; j < 16; j++)
      tbl.push_back(mk(0, 0, 0, 1, 0, j < 15 ? 1 : 0, j + 1, j < 15 ? 1 : 0, 1, 0, 0, 15 - j));
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++)
      apply(mk(0, 1, 'h40 + i, 0, 0, 1, 'h40, 1, i < 15 ? 1 : 0, 0, 0, i + 1), $sformatf("fill5_%0d", i));
    for (int k = 0; k < 10; k++)
      apply(mk(0, 1, 'h50 + k, 1, 0, 1, 'h41 + k, 1, 0, 0, 0, 16), $sformatf("pushpop_%0d", k));
    for (int j = 0; j < 16; j++)
      apply(mk(0, 0, 0, 1, 0, j < 15 ? 1 : 0, 'h4B + j, j < 15 ? 1 : 0, 1, 0, 0, 15 - j), $sformatf("drain5_%0d", j));
    // reset mid-traffic
    for (int i = 0; i < 7; i++)
      apply(mk(0, 1, 'h10 + i, 0, 0, 1, 'h10, 1, 1, 0, 0, i + 1), $sformatf("fill6_%0d", i));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "rst6");
    apply(mk(0, 1, 'h3C, 0, 0, 1, 'h3C, 1, 1, 0, 0, 1), "push3c");
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0), "pop3c");
    // drop counter saturation
    for (int i = 0; i < 16; i++)
      apply(mk(0, 1, 'h80 + i, 0, 0, 1, 'h80, 1, i < 15 ? 1 : 0, 0, 0, i + 1), $sformatf("fill7_%0d", i));
    for (int k = 0; k < 300; k++)
      apply(mk(0, 1, 'hEE, 0, 0, 1, 'h80, 1, 0, 1, k < 255 ? k + 1 : 255, 16), $sformatf("drop_%0d", k));
    // clear wins over a same-cycle drop, counting resumes afterwards
    apply(mk(0, 1, 'hEE, 0, 1, 1, 'h80, 1, 0, 0, 0, 16), "clr_vs_drop");
    apply(mk(0, 1, 'hEE, 0, 0, 1, 'h80, 1, 0, 1, 1, 16), "drop_after_clr");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
